// File: rtl/afe_seq_ctrl.sv
// rtl/afe_seq_ctrl.sv - AFE mode sequencer: power-up/reset/enable ordering, TX drain, RX overflow count
module afe_seq_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int WAKE_CYCLES   = 64,
  parameter int STOP_CYCLES   = 4,
  parameter int DRAIN_TIMEOUT = 1024,
  parameter int CNT_W         = 11
) (
  input  logic       rx_sclk_2x,
  input  logic       reset_n,
  input  logic [1:0] mode_req,
  input  logic       mode_strobe,
  input  logic       tx_fifo_empty,
  input  logic       rx_fifo_full,
  output logic       afe_reset,
  output logic       tx_en,
  output logic       rx_en,
  output logic       loopback,
  output logic       dp_reset_n,
  output logic [1:0] mode_cur,
  output logic       busy,
  output logic [7:0] ovf_cnt,
  output logic       drain_timeout
);

  typedef enum logic [2:0] {S_OFF, S_RESET, S_WAKE, S_RUN, S_DRAIN, S_STOP} state_t;

  localparam logic [1:0] M_OFF = 2'b00;
  localparam logic [1:0] M_RX  = 2'b01;
  localparam logic [1:0] M_TRX = 2'b10;
  localparam logic [1:0] M_LB  = 2'b11;

  localparam logic [CNT_W-1:0] RST_LOAD   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LOAD  = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STOP_LOAD  = CNT_W'(STOP_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       target_q, target_d;
  logic [1:0]       mode_cur_q, mode_cur_d;
  logic             pend_q, pend_d;
  logic [1:0]       pend_mode_q, pend_mode_d;
  logic [7:0]       ovf_cnt_q, ovf_cnt_d;
  logic             drain_to_q, drain_to_d;
  logic             afe_reset_q, afe_reset_d;
  logic             tx_en_q, tx_en_d;
  logic             rx_en_q, rx_en_d;
  logic             loopback_q, loopback_d;
  logic             dp_reset_n_q, dp_reset_n_d;

  logic tx_empty_s1_q, tx_empty_s2_q;
  logic rx_full_s1_q, rx_full_s2_q, rx_full_prev_q;
  logic rx_full_rise;
  logic reset_entry;

  assign rx_full_rise = rx_full_s2_q & ~rx_full_prev_q;
  assign reset_entry  = (state_d == S_RESET) && (state_q != S_RESET);

  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q != '0) ? cnt_q - CNT_ONE : cnt_q;
    target_d    = target_q;
    mode_cur_d  = mode_cur_q;
    pend_d      = pend_q;
    pend_mode_d = pend_mode_q;
    drain_to_d  = drain_to_q;
    ovf_cnt_d   = ovf_cnt_q;

    case (state_q)
      S_OFF: begin
        if (pend_q) begin
          pend_d = 1'b0;
          if (pend_mode_q != M_OFF) begin
            state_d  = S_RESET;
            target_d = pend_mode_q;
            cnt_d    = RST_LOAD;
          end
        end
      end
      S_RESET: begin
        if (cnt_q == '0) begin
          state_d = S_WAKE;
          cnt_d   = WAKE_LOAD;
        end
      end
      S_WAKE: begin
        if (cnt_q == '0) begin
          state_d    = S_RUN;
          mode_cur_d = target_q;
        end
      end
      S_RUN: begin
        // pend is left set on a mode change so STOP knows where to go next
        if (pend_q) begin
          if (pend_mode_q == mode_cur_q) begin
            pend_d = 1'b0;
          end else if (mode_cur_q == M_TRX || mode_cur_q == M_LB) begin
            state_d = S_DRAIN;
            cnt_d   = DRAIN_LOAD;
          end else begin
            state_d = S_STOP;
            cnt_d   = STOP_LOAD;
          end
        end
      end
      S_DRAIN: begin
        if (tx_empty_s2_q) begin
          state_d = S_STOP;
          cnt_d   = STOP_LOAD;
        end else if (cnt_q == '0) begin
          state_d    = S_STOP;
          cnt_d      = STOP_LOAD;
          drain_to_d = 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          mode_cur_d = M_OFF;
          pend_d     = 1'b0;
          if (pend_q && pend_mode_q != M_OFF) begin
            state_d  = S_RESET;
            target_d = pend_mode_q;
            cnt_d    = RST_LOAD;
          end else begin
            state_d = S_OFF;
          end
        end
      end
      default: state_d = S_OFF;
    endcase

    if (reset_entry) begin
      drain_to_d = 1'b0;
      ovf_cnt_d  = '0;
    end else if (rx_full_rise && (state_q == S_RUN || state_q == S_DRAIN) &&
                 (rx_en_q || loopback_q) && ovf_cnt_q != 8'hFF) begin
      ovf_cnt_d = ovf_cnt_q + 8'd1;
    end

    // A strobe landing on the consuming edge overrides the clear above
    if (mode_strobe) begin
      pend_d      = 1'b1;
      pend_mode_d = mode_req;
    end
  end

  always_comb begin
    afe_reset_d  = 1'b1;
    tx_en_d      = 1'b0;
    rx_en_d      = 1'b0;
    loopback_d   = 1'b0;
    dp_reset_n_d = 1'b0;
    case (state_d)
      S_WAKE, S_RUN, S_DRAIN: begin
        afe_reset_d  = 1'b0;
        rx_en_d      = (target_d == M_RX) || (target_d == M_TRX);
        tx_en_d      = (target_d == M_TRX);
        loopback_d   = (target_d == M_LB);
        dp_reset_n_d = (state_d != S_WAKE);
      end
      S_STOP:  afe_reset_d = 1'b0;
      default: afe_reset_d = 1'b1;
    endcase
  end

  always_ff @(posedge rx_sclk_2x or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_OFF;
      cnt_q          <= '0;
      target_q       <= M_OFF;
      mode_cur_q     <= M_OFF;
      pend_q         <= 1'b0;
      pend_mode_q    <= M_OFF;
      ovf_cnt_q      <= '0;
      drain_to_q     <= 1'b0;
      afe_reset_q    <= 1'b1;
      tx_en_q        <= 1'b0;
      rx_en_q        <= 1'b0;
      loopback_q     <= 1'b0;
      dp_reset_n_q   <= 1'b0;
      tx_empty_s1_q  <= 1'b1;
      tx_empty_s2_q  <= 1'b1;
      rx_full_s1_q   <= 1'b0;
      rx_full_s2_q   <= 1'b0;
      rx_full_prev_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      target_q       <= target_d;
      mode_cur_q     <= mode_cur_d;
      pend_q         <= pend_d;
      pend_mode_q    <= pend_mode_d;
      ovf_cnt_q      <= ovf_cnt_d;
      drain_to_q     <= drain_to_d;
      afe_reset_q    <= afe_reset_d;
      tx_en_q        <= tx_en_d;
      rx_en_q        <= rx_en_d;
      loopback_q     <= loopback_d;
      dp_reset_n_q   <= dp_reset_n_d;
      tx_empty_s1_q  <= tx_fifo_empty;
      tx_empty_s2_q  <= tx_empty_s1_q;
      rx_full_s1_q   <= rx_fifo_full;
      rx_full_s2_q   <= rx_full_s1_q;
      rx_full_prev_q <= rx_full_s2_q;
    end
  end

  assign afe_reset     = afe_reset_q;
  assign tx_en         = tx_en_q;
  assign rx_en         = rx_en_q;
  assign loopback      = loopback_q;
  assign dp_reset_n    = dp_reset_n_q;
  assign mode_cur      = mode_cur_q;
  assign busy          = (state_q != S_OFF && state_q != S_RUN) || pend_q;
  assign ovf_cnt       = ovf_cnt_q;
  assign drain_timeout = drain_to_q;

endmodule

// File: tb/tb_afe_seq_ctrl.sv
// tb/tb_afe_seq_ctrl.sv - directed bench for afe_seq_ctrl with an output-change scoreboard
module tb_afe_seq_ctrl;

  logic       clk;
  logic       reset_n;
  logic [1:0] mode_req;
  logic       mode_strobe;
  logic       tx_fifo_empty;
  logic       rx_fifo_full;
  logic       afe_reset, tx_en, rx_en, loopback, dp_reset_n;
  logic [1:0] mode_cur;
  logic       busy;
  logic [7:0] ovf_cnt;
  logic       drain_timeout;

  afe_seq_ctrl dut (
    .rx_sclk_2x   (clk),
    .reset_n      (reset_n),
    .mode_req     (mode_req),
    .mode_strobe  (mode_strobe),
    .tx_fifo_empty(tx_fifo_empty),
    .rx_fifo_full (rx_fifo_full),
    .afe_reset    (afe_reset),
    .tx_en        (tx_en),
    .rx_en        (rx_en),
    .loopback     (loopback),
    .dp_reset_n   (dp_reset_n),
    .mode_cur     (mode_cur),
    .busy         (busy),
    .ovf_cnt      (ovf_cnt),
    .drain_timeout(drain_timeout)
  );

  typedef struct {
    logic [6:0] vec;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  localparam logic [6:0] V_OFF = 7'b1000000;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] mkv(logic a, logic t, logic r, logic l, logic d, logic [1:0] m);
    return {a, t, r, l, d, m};
  endfunction

  task automatic expect_chg(int c, logic [6:0] v);
    exp_t e;
    e.vec = v;
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s @cyc %0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  task automatic at(int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic strobe(int edge_n, logic [1:0] m);
    at(edge_n - 1);
    mode_req    = m;
    mode_strobe = 1'b1;
    @(negedge clk);
    mode_strobe = 1'b0;
  endtask

  task automatic pulse_full();
    rx_fifo_full = 1'b1;
    repeat (2) @(negedge clk);
    rx_fifo_full = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Every change of {afe_reset,tx_en,rx_en,loopback,dp_reset_n,mode_cur} must match the next queued entry
  logic [6:0] mon_prev, mon_cur;
  exp_t       mon_e;
  initial begin
    mon_prev = V_OFF;
    forever begin
      @(negedge clk);
      mon_cur = {afe_reset, tx_en, rx_en, loopback, dp_reset_n, mode_cur};
      if (mon_cur !== mon_prev) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL out_change unexpected @cyc %0d actual=%b required=%b", cyc, mon_cur, mon_prev);
        end else begin
          mon_e = sb.pop_front();
          if (mon_cur !== mon_e.vec || (mon_e.cyc >= 0 && mon_e.cyc != cyc)) begin
            errors++;
            $display("FAIL out_change actual=%b @cyc %0d required=%b @cyc %0d",
                     mon_cur, cyc, mon_e.vec, mon_e.cyc);
          end
        end
        mon_prev = mon_cur;
      end
    end
  end

  initial begin
    #60000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    mode_req      = 2'b00;
    mode_strobe   = 1'b0;
    tx_fifo_empty = 1'b1;
    rx_fifo_full  = 1'b0;

    at(2);
    chk("rst_afe_reset", afe_reset, 1);
    chk("rst_enables", {tx_en, rx_en, loopback}, 0);
    chk("rst_dp_reset_n", dp_reset_n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf_cnt", ovf_cnt, 0);
    chk("rst_drain_timeout", drain_timeout, 0);
    reset_n = 1'b1;

    // Startup into RX
    expect_chg(27, mkv(0, 0, 1, 0, 0, 2'b00));
    expect_chg(91, mkv(0, 0, 1, 0, 1, 2'b01));
    strobe(10, 2'b01);
    at(50);
    chk("busy_in_wake", busy, 1);
    at(91);
    chk("busy_in_run", busy, 0);

    // Same-mode request is absorbed
    strobe(96, 2'b01);
    chk("busy_pend_same", busy, 1);
    at(98);
    chk("busy_same_cleared", busy, 0);

    // RX to TRX: no drain from RX
    expect_chg(101, mkv(0, 0, 0, 0, 0, 2'b01));
    expect_chg(105, V_OFF);
    expect_chg(121, mkv(0, 1, 1, 0, 0, 2'b00));
    expect_chg(185, mkv(0, 1, 1, 0, 1, 2'b10));
    strobe(100, 2'b10);

    // TRX teardown waits for the TX FIFO
    at(190);
    tx_fifo_empty = 1'b0;
    expect_chg(303, mkv(0, 0, 0, 0, 0, 2'b10));
    expect_chg(307, V_OFF);
    strobe(200, 2'b00);
    at(250);
    chk("busy_in_drain", busy, 1);
    at(300);
    tx_fifo_empty = 1'b1;
    at(308);
    chk("drain_no_timeout", drain_timeout, 0);
    chk("busy_off", busy, 0);

    // Loopback drain that times out, then re-sequence to RX
    expect_chg(327, mkv(0, 0, 0, 1, 0, 2'b00));
    expect_chg(391, mkv(0, 0, 0, 1, 1, 2'b11));
    strobe(310, 2'b11);
    at(392);
    tx_fifo_empty = 1'b0;
    expect_chg(1425, mkv(0, 0, 0, 0, 0, 2'b11));
    expect_chg(1429, V_OFF);
    expect_chg(1445, mkv(0, 0, 1, 0, 0, 2'b00));
    expect_chg(1509, mkv(0, 0, 1, 0, 1, 2'b01));
    strobe(400, 2'b01);
    at(1424);
    chk("timeout_not_yet", drain_timeout, 0);
    at(1426);
    chk("timeout_set", drain_timeout, 1);
    at(1430);
    chk("timeout_cleared_reset", drain_timeout, 0);
    tx_fifo_empty = 1'b1;

    // RX overflow counting and saturation
    at(1510);
    for (int i = 0; i < 300; i++) begin
      if (i == 10) chk("ovf_after_10", ovf_cnt, 10);
      pulse_full();
    end
    at(2712);
    chk("ovf_saturated", ovf_cnt, 255);

    expect_chg(2722, mkv(0, 0, 0, 0, 0, 2'b01));
    expect_chg(2726, V_OFF);
    strobe(2721, 2'b00);

    // Overwritten requests during WAKE: original target first, then the last one
    expect_chg(2747, mkv(0, 0, 1, 0, 0, 2'b00));
    expect_chg(2811, mkv(0, 0, 1, 0, 1, 2'b01));
    expect_chg(2812, mkv(0, 0, 0, 0, 0, 2'b01));
    expect_chg(2816, V_OFF);
    expect_chg(2832, mkv(0, 0, 0, 1, 0, 2'b00));
    expect_chg(2896, mkv(0, 0, 0, 1, 1, 2'b11));
    strobe(2730, 2'b01);
    at(2733);
    chk("ovf_cleared_reset", ovf_cnt, 0);
    strobe(2760, 2'b10);
    strobe(2770, 2'b11);
    at(2897);
    chk("busy_after_migrate", busy, 0);

    // Drain with FIFO already empty lasts one cycle
    expect_chg(2902, mkv(0, 0, 0, 0, 0, 2'b11));
    expect_chg(2906, V_OFF);
    strobe(2900, 2'b00);
    at(2907);
    chk("short_drain_no_timeout", drain_timeout, 0);

    // Overflow pulses in OFF are ignored
    at(2910);
    for (int i = 0; i < 5; i++) pulse_full();
    at(2932);
    chk("ovf_ignored_off", ovf_cnt, 0);

    // Asynchronous reset during WAKE
    expect_chg(2957, mkv(0, 0, 1, 0, 0, 2'b00));
    strobe(2940, 2'b01);
    at(2970);
    expect_chg(-1, V_OFF);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_afe_reset", afe_reset, 1);
    chk("async_enables", {tx_en, rx_en, loopback}, 0);
    chk("async_dp_reset_n", dp_reset_n, 0);
    chk("async_busy", busy, 0);
    at(2975);
    reset_n = 1'b1;
    at(2990);
    chk("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
